// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: control from the hazard unit, the instruction-memory handshake
// and the IF/ID-facing word. "master" is the fetch unit side, "slave" is its environment.
interface if_fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [9:0]  pc_plus4;
    logic [31:0] instr;

    modport master (
        input  stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, fetch_valid, pc_plus4, instr
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, fetch_valid, pc_plus4, instr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the PC, issues in-order imem requests, buffers returned
// words with their pc+4 in a small FIFO and drops wrong-path responses after a redirect.

module if_fetch_unit_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          reset,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] count,
    input logic [CW-1:0] discard
);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    occupancy_bound: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, inflight} + {1'b0, count}) <= DEPTH_W));

    discard_bound: assert property (@(posedge clk) disable iff (reset)
        (discard <= inflight));
endmodule

module if_fetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic             clk,
    input logic             reset,
    if_fetch_unit_if.master bus
);
    localparam int               CW       = $clog2(DEPTH + 1);
    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]      DEPTH_W  = DEPTH[CW:0];
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
    localparam logic [9:0]       PC_STEP  = 10'd4;

    logic [9:0]    pc_r;
    logic [9:0]    resp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] discard_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [9:0]    fifo_pc4_r   [DEPTH];
    logic [31:0]   fifo_instr_r [DEPTH];

    logic [CW:0]   occupancy_s;
    logic          req_s;
    logic          rsp_s;
    logic          push_s;
    logic          pop_s;
    logic [9:0]    redirect_base_s;
    logic [CW-1:0] inflight_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] discard_nxt_s;
    logic          unused_low_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign unused_low_s    = ^bus.redirect_pc[1:0];
    assign redirect_base_s = {bus.redirect_pc[9:2], 2'b00};

    // Request gate counts words still in memory as well as buffered ones, so the FIFO cannot overflow.
    always_comb begin
        occupancy_s = {1'b0, inflight_r} + {1'b0, count_r};
        req_s       = !reset && !bus.redirect && (occupancy_s < DEPTH_W);
        rsp_s       = bus.imem_rvalid && (inflight_r != CNT_ZERO);
        push_s      = rsp_s && (discard_r == CNT_ZERO) && !bus.redirect;
        pop_s       = (count_r != CNT_ZERO) && !bus.stall && !bus.redirect;
    end

    // Next-state counters; a redirect turns every response still owed into a discard.
    always_comb begin
        inflight_nxt_s = inflight_r;
        count_nxt_s    = count_r;
        discard_nxt_s  = discard_r;
        case ({req_s, rsp_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
            2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (bus.redirect) begin
            discard_nxt_s = inflight_nxt_s;
        end else if (rsp_s && (discard_r != CNT_ZERO)) begin
            discard_nxt_s = discard_r - CNT_ONE;
        end else begin
            discard_nxt_s = discard_r;
        end
    end

    // PC, response PC, FIFO pointers and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            count_r    <= CNT_ZERO;
            inflight_r <= CNT_ZERO;
            discard_r  <= CNT_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
        end else if (bus.redirect) begin
            pc_r       <= redirect_base_s;
            resp_pc_r  <= redirect_base_s;
            count_r    <= CNT_ZERO;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
        end else begin
            if (req_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_STEP;
                wr_ptr_r  <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r    <= count_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
        end
    end

    // FIFO storage; contents are only observed through count_r so they need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc4_r[wr_ptr_r]   <= resp_pc_r + PC_STEP;
            fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
        end
    end

    // Head of FIFO goes straight to IF/ID so a returned word is usable the cycle after it lands.
    always_comb begin
        bus.imem_req    = req_s;
        bus.imem_addr   = pc_r;
        bus.fetch_valid = (count_r != CNT_ZERO);
        if (count_r != CNT_ZERO) begin
            bus.pc_plus4 = fifo_pc4_r[rd_ptr_r];
            bus.instr    = fifo_instr_r[rd_ptr_r];
        end else begin
            bus.pc_plus4 = 10'h000;
            bus.instr    = NOP_INSTR;
        end
    end

    if_fetch_unit_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .inflight (inflight_r),
        .count    (count_r),
        .discard  (discard_r)
    );
endmodule
